// File: rtl/vga_fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_fb_pkg : shared encodings for the frame-buffer write scheduler |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vga_fb_pkg;

  localparam logic [1:0] OP_SET_ADDR  = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_FILL      = 2'b10;
  localparam logic [1:0] OP_SET_COLOR = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } sched_state_t;

  localparam int FB_WORDS_640X480  = 640 * 480;
  localparam int FB_WORDS_1024X768 = 1024 * 768;
  localparam int FB_WORDS_1368X768 = 1368 * 768;

endpackage
`default_nettype wire

// File: rtl/vga_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_cmd_fifo : synchronous show-ahead command queue                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vga_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == (c_AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rd];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (c_AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (c_AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_wr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_fb_wr_sched : sole driver of the frame-buffer RAM write port   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vga_fb_wr_sched
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W           = 19,
  parameter int DATA_W           = 12,
  parameter int FB_WORDS         = FB_WORDS_640X480,
  parameter int FIFO_DEPTH       = 16,
  parameter int WR_IN_BLANK_ONLY = 0
) (
  input  logic              i_pixel_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_arg,
  input  logic              i_v_blank,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_waddr,
  output logic [DATA_W-1:0] o_fb_wdata,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(FB_WORDS - 1);
  localparam logic              c_GATED    = (WR_IN_BLANK_ONLY != 0);

  sched_state_t        r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nx;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nx;
  logic [DATA_W-1:0]   r_color, w_color_nx;
  logic                r_fb_we, w_we;
  logic [ADDR_W-1:0]   r_fb_waddr, w_waddr;
  logic [DATA_W-1:0]   r_fb_wdata, w_wdata;

  logic [ADDR_W+1:0]   w_head;
  logic [1:0]          w_head_op;
  logic [ADDR_W-1:0]   w_head_arg;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_go;

  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  vga_cmd_fifo #(
    .WIDTH (ADDR_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_pixel_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_pop   (w_pop),
    .i_din   ({i_cmd_op, i_cmd_arg}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_op  = w_head[ADDR_W+1:ADDR_W];
  assign w_head_arg = w_head[ADDR_W-1:0];
  assign w_go       = ~c_GATED | i_v_blank;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_color_nx = r_color;
    w_pop      = 1'b0;
    w_we       = 1'b0;
    w_waddr    = r_fb_waddr;
    w_wdata    = r_fb_wdata;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          case (w_head_op)
            OP_SET_ADDR: begin
              w_ptr_nx = (w_head_arg <= c_PTR_LAST) ? w_head_arg : '0;
              w_pop    = 1'b1;
            end
            OP_SET_COLOR: begin
              w_color_nx = w_head_arg[DATA_W-1:0];
              w_pop      = 1'b1;
            end
            OP_WRITE: begin
              // Held at the queue head until the gate opens.
              if (w_go) begin
                w_we     = 1'b1;
                w_waddr  = r_ptr;
                w_wdata  = w_head_arg[DATA_W-1:0];
                w_ptr_nx = f_inc(r_ptr);
                w_pop    = 1'b1;
              end
            end
            default: begin
              w_pop = 1'b1;
              if (w_head_arg != '0) begin
                w_cnt_nx   = w_head_arg;
                w_state_nx = FILL;
              end
            end
          endcase
        end
      end
      FILL: begin
        if (w_go) begin
          w_we     = 1'b1;
          w_waddr  = r_ptr;
          w_wdata  = r_color;
          w_ptr_nx = f_inc(r_ptr);
          w_cnt_nx = r_cnt - ADDR_W'(1);
          if (r_cnt == ADDR_W'(1)) w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_pixel_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_pixel_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_color    <= '0;
      r_fb_we    <= 1'b0;
      r_fb_waddr <= '0;
      r_fb_wdata <= '0;
    end else begin
      r_ptr      <= w_ptr_nx;
      r_cnt      <= w_cnt_nx;
      r_color    <= w_color_nx;
      r_fb_we    <= w_we;
      r_fb_waddr <= w_waddr;
      r_fb_wdata <= w_wdata;
    end
  end

  assign o_cmd_ready = ~w_full;
  assign o_fb_we     = r_fb_we;
  assign o_fb_waddr  = r_fb_waddr;
  assign o_fb_wdata  = r_fb_wdata;
  assign o_wr_ptr    = r_ptr;
  assign o_busy      = ~w_empty | (r_state == FILL);

endmodule
`default_nettype wire
